// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/WB instruction
// flow plus HALT and external-loader memory GRANT handshake.
module cpu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  input  logic       resume,
  input  logic [3:0] operation,
  input  logic       ac_zero,
  input  logic       ext_req,
  output logic       ext_gnt,
  output logic       pc_en,
  output logic       ir_en,
  output logic       alu_en,
  output logic       file_en,
  output logic       jump,
  output logic [1:0] ac_en,
  output logic       halted,
  output logic       busy,
  output logic [7:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT,
    S_GRANT
  } state_t;

  state_t state, state_nx;
  logic [7:0] cnt_q;

  logic op_load, op_store, op_alu;
  logic op_jump, op_jz, op_halt;

  always_comb begin
    op_load  = 1'b0;
    op_store = 1'b0;
    op_alu   = 1'b0;
    op_jump  = 1'b0;
    op_jz    = 1'b0;
    op_halt  = 1'b0;
    unique case (1'b1)
      (operation == 4'b0001): op_load  = 1'b1;
      (operation == 4'b0010): op_store = 1'b1;
      (operation >= 4'b0011 &&
       operation <= 4'b1011): op_alu   = 1'b1;
      (operation == 4'b1100): op_jump  = 1'b1;
      (operation == 4'b1101): op_jz    = 1'b1;
      (operation == 4'b1111): op_halt  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Retire count advances on the edge that leaves WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'h00;
    end else if (state == S_WB) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign instr_cnt = cnt_q;

  always_comb begin
    state_nx = state;
    ext_gnt  = 1'b0;
    pc_en    = 1'b0;
    ir_en    = 1'b0;
    alu_en   = 1'b0;
    file_en  = 1'b0;
    jump     = 1'b0;
    ac_en    = 2'b00;
    halted   = 1'b0;
    busy     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (ext_req) begin
          state_nx = S_GRANT;
        end else if (run || step) begin
          state_nx = S_FETCH;
        end
      end
      S_FETCH: begin
        busy     = 1'b1;
        ir_en    = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        busy     = 1'b1;
        state_nx = op_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        busy     = 1'b1;
        alu_en   = op_alu;
        file_en  = op_load | op_store;
        state_nx = S_WB;
      end
      S_WB: begin
        busy  = 1'b1;
        pc_en = 1'b1;
        jump  = op_jump | (op_jz & ac_zero);
        unique case (1'b1)
          op_load: ac_en = 2'b01;
          op_alu:  ac_en = 2'b10;
          default: ac_en = 2'b00;
        endcase
        // Loader waits for IDLE; step never chains past one instruction.
        if (ext_req) begin
          state_nx = S_IDLE;
        end else if (run) begin
          state_nx = S_FETCH;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) begin
          state_nx = S_IDLE;
        end else if (ext_req) begin
          state_nx = S_GRANT;
        end
      end
      S_GRANT: begin
        ext_gnt = 1'b1;
        if (!ext_req) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus
// random programs checked against a per-instruction table model.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       resume = 1'b0;
  logic [3:0] operation = 4'h0;
  logic       ac_zero = 1'b0;
  logic       ext_req = 1'b0;
  logic       ext_gnt, pc_en, ir_en, alu_en, file_en, jump;
  logic       halted, busy;
  logic [1:0] ac_en;
  logic [7:0] instr_cnt;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] m_cnt = 8'h00;
  int opq[$];
  int azq[$];

  logic [9:0] vec;
  assign vec = {ext_gnt, halted, busy, ir_en, pc_en,
                alu_en, file_en, jump, ac_en};

  localparam logic [9:0] V_IDLE  = 10'h000;
  localparam logic [9:0] V_HALT  = 10'h100;
  localparam logic [9:0] V_GRANT = 10'h200;

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .resume(resume), .operation(operation),
    .ac_zero(ac_zero), .ext_req(ext_req),
    .ext_gnt(ext_gnt), .pc_en(pc_en), .ir_en(ir_en),
    .alu_en(alu_en), .file_en(file_en), .jump(jump),
    .ac_en(ac_en), .halted(halted), .busy(busy),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // Expected outputs for cycle 'slot' (0..3) of an instruction.
  function automatic logic [9:0] expect_vec(int op, int slot, int az);
    logic [9:0] v;
    bit alu;
    v = 10'h080;
    alu = (op >= 3) && (op <= 11);
    if (slot == 0) v[6] = 1'b1;
    if (slot == 2) begin
      v[4] = alu;
      v[3] = (op == 1) || (op == 2);
    end
    if (slot == 3) begin
      v[5] = 1'b1;
      v[2] = (op == 12) || (op == 13 && az != 0);
      if (op == 1) v[1:0] = 2'b01;
      else if (alu) v[1:0] = 2'b10;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vec(input string tag, input logic [9:0] exp);
    n_chk++;
    assert (vec === exp) else begin
      n_fail++;
      $error("FAIL %s: outputs observed %b expected %b", tag, vec, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    n_chk++;
    assert (instr_cnt === m_cnt) else begin
      n_fail++;
      $error("FAIL %s: instr_cnt observed %h expected %h", tag, instr_cnt, m_cnt);
    end
  endtask

  task automatic fill_rand(input int n);
    opq.delete();
    azq.delete();
    for (int i = 0; i < n; i++) opq.push_back(int'($urandom_range(14, 0)));
  endtask

  // Runs opq back to back from IDLE, then stops and checks IDLE.
  task automatic run_q();
    int op, az;
    run = 1'b1;
    for (int i = 0; i < opq.size(); i++) begin
      op = opq[i];
      az = (i < azq.size()) ? azq[i] : int'($urandom_range(1, 0));
      operation = op[3:0];
      ac_zero = az[0];
      for (int s = 0; s < 4; s++) begin
        tick();
        chk_vec($sformatf("prog i%0d s%0d op%0d", i, s, op), expect_vec(op, s, az));
        if (s == 3) begin
          chk_cnt("cnt_in_wb");
          m_cnt = m_cnt + 8'd1;
          if (i == opq.size() - 1) run = 1'b0;
        end
      end
    end
    tick();
    chk_vec("prog_end_idle", V_IDLE);
    chk_cnt("prog_end_cnt");
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk_vec("async_reset_vec", V_IDLE);
    chk_cnt("async_reset_cnt");
    run = 1'b1;
    tick();
    chk_vec("held_reset_vec", V_IDLE);
    #2 rst = 1'b1;
    run = 1'b0;
    tick();
    chk_vec("idle_after_reset", V_IDLE);

    // NOP, LOAD, ALU, STORE; first edge after reset release runs normally
    opq = {};
    azq = {};
    opq.push_back(0); opq.push_back(1);
    opq.push_back(3); opq.push_back(2);
    run_q();

    // JZ taken then not taken
    opq = {};
    azq = {};
    opq.push_back(13); opq.push_back(13);
    azq.push_back(1); azq.push_back(0);
    run_q();

    fill_rand(20);
    run_q();

    // HALT, then resume together with ext_req (resume wins)
    run = 1'b1;
    operation = 4'hF;
    tick(); chk_vec("halt_fetch", expect_vec(15, 0, 0));
    tick(); chk_vec("halt_decode", expect_vec(15, 1, 0));
    tick(); chk_vec("halt_state", V_HALT);
    chk_cnt("halt_cnt");
    tick(); chk_vec("halt_hold", V_HALT);
    resume = 1'b1;
    ext_req = 1'b1;
    tick();
    resume = 1'b0;
    ext_req = 1'b0;
    chk_vec("resume_idle", V_IDLE);
    operation = 4'h0;
    for (int s = 0; s < 4; s++) begin
      tick();
      chk_vec($sformatf("post_resume s%0d", s), expect_vec(0, s, 0));
      if (s == 3) begin
        m_cnt = m_cnt + 8'd1;
        run = 1'b0;
      end
    end
    tick(); chk_vec("post_resume_idle", V_IDLE);
    chk_cnt("post_resume_cnt");

    // HALT left through GRANT
    run = 1'b1;
    operation = 4'hF;
    tick(); tick(); tick();
    chk_vec("halt2_state", V_HALT);
    run = 1'b0;
    ext_req = 1'b1;
    tick(); chk_vec("halt_grant", V_GRANT);
    tick(); chk_vec("halt_grant_hold", V_GRANT);
    ext_req = 1'b0;
    tick(); chk_vec("halt_grant_release", V_IDLE);
    tick(); chk_vec("halt_grant_idle", V_IDLE);

    // ext_req raised in EXEC must not abort the instruction
    run = 1'b1;
    operation = 4'h5;
    ac_zero = 1'b0;
    tick(); chk_vec("xr_fetch", expect_vec(5, 0, 0));
    tick(); chk_vec("xr_decode", expect_vec(5, 1, 0));
    tick(); chk_vec("xr_exec", expect_vec(5, 2, 0));
    ext_req = 1'b1;
    tick(); chk_vec("xr_wb", expect_vec(5, 3, 0));
    m_cnt = m_cnt + 8'd1;
    tick(); chk_vec("xr_idle", V_IDLE);
    for (int k = 0; k < 4; k++) begin
      tick(); chk_vec($sformatf("xr_grant%0d", k), V_GRANT);
    end
    run = 1'b0;
    ext_req = 1'b0;
    tick(); chk_vec("xr_release", V_IDLE);
    chk_cnt("xr_cnt");

    // async reset while granted
    ext_req = 1'b1;
    tick(); chk_vec("grant_pre_reset", V_GRANT);
    #2 rst = 1'b0;
    #1 chk_vec("grant_reset_vec", V_IDLE);
    m_cnt = 8'h00;
    chk_cnt("grant_reset_cnt");
    ext_req = 1'b0;
    rst = 1'b1;
    tick(); chk_vec("grant_reset_idle", V_IDLE);

    // single step; step in busy states (incl. WB) ignored
    operation = 4'h2;
    step = 1'b1;
    tick(); chk_vec("step_fetch", expect_vec(2, 0, 0));
    step = 1'b0;
    tick(); chk_vec("step_decode", expect_vec(2, 1, 0));
    step = 1'b1;
    tick(); chk_vec("step_exec", expect_vec(2, 2, 0));
    tick(); chk_vec("step_wb", expect_vec(2, 3, 0));
    m_cnt = m_cnt + 8'd1;
    tick();
    step = 1'b0;
    chk_vec("step_idle", V_IDLE);
    tick(); chk_vec("step_stay_idle", V_IDLE);
    chk_cnt("step_cnt");

    // counter wrap
    fill_rand(255 - int'(m_cnt));
    run_q();
    chk_cnt("cnt_ff");
    fill_rand(1);
    run_q();
    n_chk++;
    assert (instr_cnt === 8'h00) else begin
      n_fail++;
      $error("FAIL wrap: instr_cnt observed %h expected 00", instr_cnt);
    end

    // reach FF again, then reset asynchronously mid EXEC
    fill_rand(255);
    run_q();
    chk_cnt("cnt_ff_again");
    run = 1'b1;
    operation = 4'h4;
    tick(); tick(); tick();
    chk_vec("rst_exec_pre", expect_vec(4, 2, 0));
    #2 rst = 1'b0;
    #1 chk_vec("rst_exec_vec", V_IDLE);
    m_cnt = 8'h00;
    chk_cnt("rst_exec_cnt");
    #2 rst = 1'b1;
    run = 1'b0;
    tick(); chk_vec("rst_exec_idle", V_IDLE);
    fill_rand(3);
    run_q();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately, independent of clk.
REQ-003 run  input  1  level; 1 = execute instructions back-to-back.
REQ-004 step  input  1  single-cycle pulse; executes exactly one instruction from IDLE.
REQ-005 resume  input  1  single-cycle pulse; leaves HALT.
REQ-006 operation  input  4  opcode from instruction register; valid from DECODE onward.
REQ-007 ac_zero  input  1  1 when accumulator equals 8'h00.
REQ-008 ext_req  input  1  external loader requests instruction/file memory.
REQ-009 ext_gnt  output  1  memory granted to external loader.
REQ-010 pc_en, ir_en, alu_en, file_en, jump  output  1 each  datapath strobes.
REQ-011 ac_en  output  2  00 hold, 01 load from file, 10 load from ALU, 11 unused.
REQ-012 halted  output  1  sequencer in HALT.
REQ-013 busy  output  1  sequencer in FETCH, DECODE, EXEC or WB.
REQ-014 instr_cnt  output  8  retired-instruction counter.

Function
REQ-015 States SHALL be IDLE, FETCH, DECODE, EXEC, WB, HALT, GRANT; every non-halt instruction takes exactly 4 cycles (FETCH..WB).
REQ-016 Opcodes: 0000 NOP; 0001 LOAD (file->ac); 0010 STORE (ac->file); 0011-1011 ALU ops; 1100 JUMP; 1101 JZ; 1110 NOP; 1111 HALT.
REQ-017 IDLE: ext_req=1 -> GRANT (highest priority); else run=1 or step=1 -> FETCH; else stay.
REQ-018 FETCH: ir_en=1 for one cycle; next DECODE.
REQ-019 DECODE: no strobes; opcode 1111 -> HALT, else EXEC.
REQ-020 EXEC: alu_en=1 for 0011-1011; file_en=1 for 0001 and 0010; no strobes otherwise; next WB.
REQ-021 WB: pc_en=1 always; jump=1 for 1100, or for 1101 when ac_zero=1 (sampled in WB); ac_en=01 for LOAD, 10 for ALU ops, 00 otherwise; instr_cnt increments.
REQ-022 After WB: ext_req=1 -> IDLE; else run=1 -> FETCH; else IDLE (step executes one instruction only).
REQ-023 All strobes SHALL be Moore outputs of the current state/opcode, one-cycle, and 0 in IDLE, HALT, GRANT.
REQ-024 HALT: halted=1; HALT instruction does not increment instr_cnt or assert pc_en; resume=1 -> IDLE; ext_req=1 -> GRANT (resume has priority if both).
REQ-025 GRANT: ext_gnt=1 while ext_req=1; ext_req=0 -> IDLE (leaving from HALT also returns to IDLE); ext_gnt never asserted outside GRANT.
REQ-026 ext_req raised mid-instruction SHALL NOT abort it; grant occurs only after WB completes and IDLE is entered.
REQ-027 run/step/resume/ext_req/operation/ac_zero SHALL be treated as synchronous to clk.
REQ-028 instr_cnt SHALL wrap 8'hFF -> 8'h00 without flag.
REQ-029 step pulse during busy states SHALL be ignored.

Reset
REQ-030 rst=0 SHALL force state IDLE and all outputs 0 (ext_gnt, strobes, ac_en=00, halted, busy, instr_cnt=8'h00), including mid-instruction and during GRANT.
REQ-031 First rising edge after rst returns to 1 SHALL evaluate IDLE transitions normally.

Verification
REQ-032 run=1, program NOP,LOAD,ALU(0011),STORE -> ir_en at cycles 1,5,9,13 after first FETCH; file_en/ac_en=01 in instr 2; alu_en/ac_en=10 in instr 3; file_en/ac_en=00 in instr 4; instr_cnt=4.
REQ-033 JZ with ac_zero=1 then with ac_zero=0 -> jump=1 with pc_en=1 in first WB; jump=0, pc_en=1 in second.
REQ-034 run=1, HALT opcode -> halted=1 after DECODE, no pc_en, instr_cnt unchanged; resume pulse -> IDLE, then FETCH next cycle.
REQ-035 ext_req asserted during EXEC -> WB completes, IDLE, GRANT, ext_gnt=1 until ext_req=0; no strobes while granted.
REQ-036 rst=0 asynchronously during EXEC with instr_cnt=8'hFF then 255 more instructions -> outputs 0 immediately; counter restarts at 0; separately 256 instructions wrap instr_cnt to 8'h00.
REQ-037 run=0, one step pulse -> exactly one 4-cycle instruction, instr_cnt+1, back to IDLE; step during busy ignored.
